// File: rtl/Falco_pkg.sv
// Shared sizes and helpers for the issue-select slice.
package Falco_pkg;
  localparam int IQ_DEPTH = 8;
  localparam int IQ_IDX_W = 3;

  typedef logic [IQ_IDX_W-1:0] iq_idx_t;
  typedef logic [IQ_DEPTH-1:0] iq_mask_t;
  // older[i][j] = 1 : slot i was allocated before slot j
  typedef logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0] iq_age_t;

  function automatic iq_idx_t oh2idx(input iq_mask_t oh);
    iq_idx_t r;
    r = '0;
    for (int i = 0; i < IQ_DEPTH; i++)
      if (oh[i]) r = r | iq_idx_t'(i);
    return r;
  endfunction

  function automatic iq_mask_t idx2oh(input iq_idx_t idx);
    return iq_mask_t'(1) << idx;
  endfunction
endpackage

// File: rtl/issue_select8_age.sv
// iq_age_matrix8: 8x8 age matrix plus two oldest-of-mask picks.
// sel1 is the oldest candidate once sel0 has been removed.
module iq_age_matrix8 import Falco_pkg::*; (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic [IQ_DEPTH-1:0] valid_i,
  input  logic                alloc_valid0_i,
  input  logic [IQ_IDX_W-1:0] alloc_idx0_i,
  input  logic                alloc_valid1_i,
  input  logic [IQ_IDX_W-1:0] alloc_idx1_i,
  input  logic [IQ_DEPTH-1:0] cand_i,
  output logic [IQ_DEPTH-1:0] sel0_o,
  output logic [IQ_DEPTH-1:0] sel1_o
);
  iq_age_t older_q, older_d;

  // Slot i is oldest when no other masked slot is older than it.
  function automatic iq_mask_t oldest(input iq_mask_t m, input iq_age_t age);
    iq_mask_t o;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      o[i] = m[i];
      for (int j = 0; j < IQ_DEPTH; j++)
        if (m[j] && age[j][i]) o[i] = 1'b0;
    end
    return o;
  endfunction

  // New slot becomes younger than every valid slot; lane 1 also younger than lane 0.
  always_comb begin
    older_d = older_q;
    if (alloc_valid0_i) begin
      older_d[alloc_idx0_i] = '0;
      for (int j = 0; j < IQ_DEPTH; j++)
        older_d[j][alloc_idx0_i] = valid_i[j] && (iq_idx_t'(j) != alloc_idx0_i);
    end
    if (alloc_valid1_i) begin
      older_d[alloc_idx1_i] = '0;
      for (int j = 0; j < IQ_DEPTH; j++)
        older_d[j][alloc_idx1_i] = (valid_i[j] || (alloc_valid0_i && alloc_idx0_i == iq_idx_t'(j)))
                                   && (iq_idx_t'(j) != alloc_idx1_i);
    end
  end

  // Matrix register; flush wipes it along with the slots.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) older_q <= '0;
    else                  older_q <= older_d;
  end

  assign sel0_o = oldest(cand_i, older_q);
  assign sel1_o = oldest(cand_i & ~sel0_o, older_q);
endmodule

// File: rtl/issue_select8.sv
// issue_select8: holds slot valid/ready/age and picks the two oldest ready
// slots for the two FU ports. Optional macro ISSUE_SELECT_WAKEUP_BYPASS_EN
// lets a same-cycle wakeup make a slot selectable.
module issue_select8 import Falco_pkg::*; (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                alloc_valid0_i,
  input  logic                alloc_valid1_i,
  input  logic [IQ_IDX_W-1:0] alloc_idx0_i,
  input  logic [IQ_IDX_W-1:0] alloc_idx1_i,
  input  logic                alloc_rdy0_i,
  input  logic                alloc_rdy1_i,
  input  logic [IQ_DEPTH-1:0] wakeup_mask_i,
  input  logic                issue_ready0_i,
  input  logic                issue_ready1_i,
  output logic                issue_valid0_o,
  output logic                issue_valid1_o,
  output logic [IQ_IDX_W-1:0] issue_idx0_o,
  output logic [IQ_IDX_W-1:0] issue_idx1_o,
  output logic [IQ_IDX_W-1:0] dispatch_slot_idx0_o,
  output logic [IQ_IDX_W-1:0] dispatch_slot_idx1_o,
  output logic                dispatch_slot_idx0_valid_o,
  output logic                dispatch_slot_idx1_valid_o,
  output logic [IQ_DEPTH-1:0] slot_valid_o,
  output logic [3:0]          occupancy_o
);
  iq_mask_t valid_q, valid_d, rdy_q, rdy_d;
  iq_mask_t cand, sel0, sel1, fire_mask, a0m, a1m;
  logic [3:0] occ_q, occ_d;
  logic fire0, fire1;

`ifdef ISSUE_SELECT_WAKEUP_BYPASS_EN
  assign cand = valid_q & (rdy_q | wakeup_mask_i);
`else
  assign cand = valid_q & rdy_q;
`endif

  iq_age_matrix8 u_age (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .valid_i        (valid_q),
    .alloc_valid0_i (alloc_valid0_i),
    .alloc_idx0_i   (alloc_idx0_i),
    .alloc_valid1_i (alloc_valid1_i),
    .alloc_idx1_i   (alloc_idx1_i),
    .cand_i         (cand),
    .sel0_o         (sel0),
    .sel1_o         (sel1)
  );

  assign issue_valid0_o             = |sel0;
  assign issue_valid1_o             = |sel1;
  assign issue_idx0_o               = oh2idx(sel0);
  assign issue_idx1_o               = oh2idx(sel1);
  assign dispatch_slot_idx0_o       = issue_idx0_o;
  assign dispatch_slot_idx1_o       = issue_idx1_o;
  assign fire0                      = issue_valid0_o & issue_ready0_i;
  assign fire1                      = issue_valid1_o & issue_ready1_i;
  assign dispatch_slot_idx0_valid_o = fire0;
  assign dispatch_slot_idx1_valid_o = fire1;
  assign slot_valid_o               = valid_q;
  assign occupancy_o                = occ_q;

  assign fire_mask = (fire0 ? sel0 : '0) | (fire1 ? sel1 : '0);
  assign a0m       = alloc_valid0_i ? idx2oh(alloc_idx0_i) : '0;
  assign a1m       = alloc_valid1_i ? idx2oh(alloc_idx1_i) : '0;

  // Per-slot next state: allocation beats fire clear beats wakeup.
  always_comb begin
    valid_d = valid_q;
    rdy_d   = rdy_q;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      if (a0m[i] || a1m[i]) begin
        valid_d[i] = 1'b1;
        rdy_d[i]   = a1m[i] ? alloc_rdy1_i : alloc_rdy0_i;
      end else if (fire_mask[i]) begin
        valid_d[i] = 1'b0;
        rdy_d[i]   = 1'b0;
      end else if (wakeup_mask_i[i] && valid_q[i]) begin
        rdy_d[i]   = 1'b1;
      end
    end
    occ_d = occ_q + 4'(alloc_valid0_i) + 4'(alloc_valid1_i) - 4'(fire0) - 4'(fire1);
  end

  // Slot state registers; reset and flush both empty the queue.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      valid_q <= '0;
      rdy_q   <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rdy_q   <= rdy_d;
      occ_q   <= occ_d;
    end
  end

  // Overwriting a live slot that is not leaving this cycle is a finder bug.
  a_alloc0_free: assert property (@(posedge clk_i) disable iff (rst_i)
    (alloc_valid0_i && !flush_i) |-> (!valid_q[alloc_idx0_i] || fire_mask[alloc_idx0_i]));
  a_alloc1_free: assert property (@(posedge clk_i) disable iff (rst_i)
    (alloc_valid1_i && !flush_i) |-> (!valid_q[alloc_idx1_i] || fire_mask[alloc_idx1_i]));
endmodule
